// File: rtl/insn_stream_fifo_if.sv
// Handshake bundle between the prefetcher/decoder and the byte queue.
// Master drives push/pop requests; slave returns peek data and status.
interface insn_stream_fifo_if #(
  parameter int DEPTH = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          rd_en;
  logic          rd_two;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          rd_valid2;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output flush, wr_en, wr_data,
    output rd_en, rd_two,
    input  full, rd_data, rd_valid,
    input  rd_valid2, empty, count
  );

  modport slave (
    input  flush, wr_en, wr_data,
    input  rd_en, rd_two,
    output full, rd_data, rd_valid,
    output rd_valid2, empty, count
  );
endinterface

// File: rtl/insn_stream_fifo.sv
// Byte-wide instruction stream queue with 1/2-byte pop and peek.
// Full asserts one entry early to absorb an in-flight second byte.
module insn_stream_fifo #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic reset,
  insn_stream_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, rd_ptr_next;
  logic [PW-1:0] wr_ptr, wr_ptr_next;
  logic [PW-1:0] rd_ptr_1;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] need;
  logic          wr_ok, rd_ok;

  function automatic logic [PW-1:0] step(
    input logic [PW-1:0] p,
    input logic          two
  );
    logic [PW:0] s;
    s = {1'b0, p} + (two ? (PW+1)'(2) : (PW+1)'(1));
    if (s >= (PW+1)'(DEPTH))
      s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Acceptance rules and next pointer/count values.
  always_comb begin
    need        = bus.rd_two ? CW'(2) : CW'(1);
    wr_ok       = bus.wr_en && !bus.flush &&
                  (count < CW'(DEPTH));
    rd_ok       = bus.rd_en && !bus.flush &&
                  (count >= need);
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_ok)
        wr_ptr_next = step(wr_ptr, 1'b0);
      if (rd_ok)
        rd_ptr_next = step(rd_ptr, bus.rd_two);
      count_next = count + CW'(wr_ok)
                 - (rd_ok ? need : '0);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Byte storage; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok)
      mem[wr_ptr] <= bus.wr_data;
  end

  assign rd_ptr_1 = step(rd_ptr, 1'b0);

  assign bus.count     = count;
  assign bus.empty     = (count == '0);
  assign bus.rd_valid  = (count != '0);
  assign bus.rd_valid2 = (count >= CW'(2));
  assign bus.full      = (count >= CW'(DEPTH - 1));

  assign bus.rd_data[7:0]  =
    bus.rd_valid  ? mem[rd_ptr]   : 8'h00;
  assign bus.rd_data[15:8] =
    bus.rd_valid2 ? mem[rd_ptr_1] : 8'h00;
endmodule

// File: tb/tb_insn_stream_fifo.sv
// Directed bench for insn_stream_fifo with a queue-based model
// checked every cycle plus literal expectations at key points.
module tb_insn_stream_fifo;
  localparam int DEPTH = 6;

  logic clk;
  logic reset;

  insn_stream_fifo_if #(.DEPTH(DEPTH)) bus ();

  insn_stream_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs  = 0;
  int total = 0;
  bit armed = 0;

  logic [7:0] mq [$];

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  task automatic model(
    input bit         we,
    input logic [7:0] wd,
    input bit         re,
    input bit         two,
    input bit         fl,
    input bit         rs
  );
    int sz;
    int n;
    sz = mq.size();
    n  = two ? 2 : 1;
    if (rs || fl) begin
      mq.delete();
      return;
    end
    if (re && sz >= n)
      repeat (n) void'(mq.pop_front());
    if (we && sz < DEPTH)
      mq.push_back(wd);
  endtask

  task automatic tick(
    input bit         we,
    input logic [7:0] wd,
    input bit         re,
    input bit         two,
    input bit         fl,
    input bit         rs
  );
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_two  = two;
    bus.flush   = fl;
    reset       = rs;
    @(posedge clk);
    model(we, wd, re, two, fl, rs);
    #1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.rd_two  = 1'b0;
    bus.flush   = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    tick(1, d, 0, 0, 0, 0);
  endtask

  task automatic pop(input bit two);
    tick(0, 8'h00, 1, two, 0, 0);
  endtask

  // Model comparison away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      int sz;
      logic [15:0] ed;
      sz = mq.size();
      ed = 16'h0000;
      if (sz >= 1) ed[7:0]  = mq[0];
      if (sz >= 2) ed[15:8] = mq[1];
      chk("m_count", 32'(bus.count), 32'(sz));
      chk("m_data", 32'(bus.rd_data), 32'(ed));
      chk("m_empty", 32'(bus.empty), 32'(sz == 0));
      chk("m_full", 32'(bus.full),
          32'(sz >= DEPTH - 1));
      chk("m_valid", 32'(bus.rd_valid), 32'(sz >= 1));
      chk("m_valid2", 32'(bus.rd_valid2),
          32'(sz >= 2));
    end
  end

  initial begin
    reset       = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.rd_two  = 1'b0;

    tick(0, 8'h00, 0, 0, 0, 1);
    armed = 1;
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_data", 32'(bus.rd_data), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_valid", 32'(bus.rd_valid), 0);

    wr(8'h11); wr(8'h22); wr(8'h33);
    chk("w3_count", 32'(bus.count), 3);
    chk("w3_data", 32'(bus.rd_data), 32'h2211);
    chk("w3_valid2", 32'(bus.rd_valid2), 1);
    chk("w3_full", 32'(bus.full), 0);

    pop(1);
    chk("p2_data", 32'(bus.rd_data), 32'h0033);
    pop(0);
    chk("p1_data", 32'(bus.rd_data), 0);
    chk("p1_empty", 32'(bus.empty), 1);
    chk("p1_count", 32'(bus.count), 0);

    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    chk("w4_full", 32'(bus.full), 0);
    wr(8'h05);
    chk("w5_full", 32'(bus.full), 1);
    chk("w5_count", 32'(bus.count), 5);
    wr(8'h06);
    chk("w6_count", 32'(bus.count), 6);
    wr(8'h07);
    chk("w7_count", 32'(bus.count), 6);
    chk("w7_head", 32'(bus.rd_data[7:0]), 32'h01);

    pop(1); pop(1);
    for (int i = 0; i < 4; i++)
      wr(8'hA0 + 8'(i));
    begin
      logic [7:0] want [6];
      want = '{8'h05, 8'h06, 8'hA0,
               8'hA1, 8'hA2, 8'hA3};
      for (int i = 0; i < 6; i++) begin
        chk("wrap_head", 32'(bus.rd_data[7:0]),
            32'(want[i]));
        pop(0);
      end
    end
    chk("wrap_empty", 32'(bus.empty), 1);

    for (int i = 0; i < DEPTH; i++)
      wr(8'hB0 + 8'(i));
    tick(1, 8'hC0, 1, 0, 0, 0);
    chk("full_rw_count", 32'(bus.count), 5);
    chk("full_rw_data", 32'(bus.rd_data), 32'hB2B1);
    tick(1, 8'hC1, 1, 1, 0, 0);
    chk("rw2_count", 32'(bus.count), 4);
    chk("rw2_data", 32'(bus.rd_data), 32'hB4B3);
    pop(1); pop(1);
    chk("drain_data", 32'(bus.rd_data), 0);

    tick(1, 8'h77, 1, 0, 0, 0);
    chk("ew_count", 32'(bus.count), 1);
    chk("ew_data", 32'(bus.rd_data), 32'h0077);
    pop(0);
    wr(8'h5A);
    pop(1);
    chk("under_count", 32'(bus.count), 1);
    chk("under_data", 32'(bus.rd_data), 32'h005A);
    pop(0);
    chk("under_pop", 32'(bus.count), 0);

    for (int i = 0; i < 4; i++)
      wr(8'hD0 + 8'(i));
    tick(1, 8'hEE, 1, 1, 1, 0);
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_empty", 32'(bus.empty), 1);
    chk("fl_data", 32'(bus.rd_data), 0);
    wr(8'h90);
    chk("fl_w_data", 32'(bus.rd_data), 32'h0090);
    pop(0);

    for (int i = 0; i < 4; i++)
      wr(8'hE0 + 8'(i));
    tick(1, 8'hEE, 1, 1, 0, 1);
    chk("rs_count", 32'(bus.count), 0);
    chk("rs_empty", 32'(bus.empty), 1);
    chk("rs_data", 32'(bus.rd_data), 0);
    wr(8'h90);
    chk("rs_w_data", 32'(bus.rd_data), 32'h0090);

    @(negedge clk);
    #1;
    armed = 0;
    $display("Result: errors=%0d of %0d checks",
             errs, total);
    $finish;
  end
endmodule
